// File: rtl/key_buffer.sv
// key_buffer: FIFO of ASCII characters decoded from PS/2 key-release scan codes,
// with backspace deleting the newest entry and a sticky overflow flag.
module key_buffer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key,
    input  logic       keyChange,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic [4:0] count,
    output logic       overflow
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [7:0]    code;
    logic          valid, wr, pop, dl;
    always_comb begin
        code = 8'h00;
        case (key)
            8'h45: code = 8'h30;  8'h16: code = 8'h31;  8'h1E: code = 8'h32;  8'h26: code = 8'h33;
            8'h25: code = 8'h34;  8'h2E: code = 8'h35;  8'h36: code = 8'h36;  8'h3D: code = 8'h37;
            8'h3E: code = 8'h38;  8'h46: code = 8'h39;
            8'h1C: code = 8'h41;  8'h32: code = 8'h42;  8'h21: code = 8'h43;  8'h23: code = 8'h44;
            8'h24: code = 8'h45;  8'h2B: code = 8'h46;  8'h34: code = 8'h47;  8'h33: code = 8'h48;
            8'h43: code = 8'h49;  8'h3B: code = 8'h4A;  8'h42: code = 8'h4B;  8'h4B: code = 8'h4C;
            8'h3A: code = 8'h4D;  8'h31: code = 8'h4E;  8'h44: code = 8'h4F;  8'h4D: code = 8'h50;
            8'h15: code = 8'h51;  8'h2D: code = 8'h52;  8'h1B: code = 8'h53;  8'h2C: code = 8'h54;
            8'h3C: code = 8'h55;  8'h2A: code = 8'h56;  8'h1D: code = 8'h57;  8'h22: code = 8'h58;
            8'h35: code = 8'h59;  8'h1A: code = 8'h5A;
            8'h29: code = 8'h20;  8'h5A: code = 8'h0D;
            default: code = 8'h00;
        endcase
    end
    assign valid = code != 8'h00;
    assign empty = count == 5'd0;
    assign full  = count == 5'(DEPTH);
    assign pop   = rd_en && !empty;
    // a full buffer still accepts a push when the head is popped in the same cycle
    assign wr    = keyChange && valid && (!full || rd_en);
    // with a single entry, delete and pop together remove it only once
    assign dl    = keyChange && key == 8'h66 && !empty && !(pop && count == 5'd1);
    assign dout  = empty ? 8'h00 : mem[head];
    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            if (keyChange && valid && full && !rd_en) overflow <= 1'b1;
            if (wr) begin
                mem[tail] <= code;
                tail      <= tail + AW'(1);
            end
            if (dl) tail <= tail - AW'(1);
            if (pop) head <= head + AW'(1);
            count <= count + 5'(wr) - 5'(pop) - 5'(dl);
        end
    end
endmodule

// File: tb/tb_key_buffer.sv
// tb_key_buffer: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_key_buffer;
    localparam int DEPTH = 8;
    localparam logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] key = 8'h00;
    logic       keyChange = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       empty, full, overflow;
    logic [4:0] count;

    key_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .key(key), .keyChange(keyChange), .rd_en(rd_en),
        .dout(dout), .empty(empty), .full(full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;

    function automatic logic [8:0] ref_dec(logic [7:0] k);
        for (int i = 0; i < 10; i++) if (DIG[i] == k) return {1'b1, 8'(8'h30 + i)};
        for (int i = 0; i < 26; i++) if (LET[i] == k) return {1'b1, 8'(8'h41 + i)};
        if (k == 8'h29) return {1'b1, 8'h20};
        if (k == 8'h5A) return {1'b1, 8'h0D};
        return 9'h000;
    endfunction

    // Reference: apply the buffer rules to a queue of characters
    task automatic model(input logic rs, input logic kc, input logic [7:0] k, input logic rd);
        logic [8:0] d;
        int         n;
        d = ref_dec(k);
        n = q.size();
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (kc && d[8]) begin
            if (n < DEPTH || rd) begin
                if (rd && n > 0) void'(q.pop_front());
                q.push_back(d[7:0]);
            end else m_ovf = 1'b1;
        end else if (kc && k == 8'h66 && n > 0) begin
            if (rd) begin
                void'(q.pop_front());
                if (n > 1) void'(q.pop_back());
            end else void'(q.pop_back());
        end else if (rd && n > 0) void'(q.pop_front());
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("count", 8'(count), 8'(q.size()));
        chk("empty", 8'(empty), 8'(q.size() == 0));
        chk("full", 8'(full), 8'(q.size() == DEPTH));
        chk("overflow", 8'(overflow), 8'(m_ovf));
        if (q.size() > 0) chk("dout", dout, q[0]);
    endtask

    task automatic step(input logic rs, input logic kc, input logic [7:0] k, input logic rd);
        reset = rs;
        keyChange = kc;
        key = k;
        rd_en = rd;
        @(posedge clk);
        model(rs, kc, k, rd);
        #1;
        reset = 1'b0;
        keyChange = 1'b0;
        rd_en = 1'b0;
    endtask

    typedef struct {
        logic       kc;
        logic [7:0] k;
        logic       rd;
        logic [4:0] e_cnt;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vt[$];

    initial begin
        vt = '{
            '{1'b1, 8'h16, 1'b0, 5'd1, 8'h31},
            '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00},
            '{1'b1, 8'h1C, 1'b0, 5'd1, 8'h41},
            '{1'b1, 8'h32, 1'b0, 5'd2, 8'h41},
            '{1'b1, 8'h21, 1'b0, 5'd3, 8'h41},
            '{1'b1, 8'h66, 1'b0, 5'd2, 8'h41},
            '{1'b0, 8'h00, 1'b1, 5'd1, 8'h42},
            '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00},
            '{1'b1, 8'hF0, 1'b0, 5'd0, 8'h00},
            '{1'b1, 8'h76, 1'b0, 5'd0, 8'h00},
            '{1'b1, 8'hE0, 1'b0, 5'd0, 8'h00},
            '{1'b1, 8'h66, 1'b0, 5'd0, 8'h00},
            '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00},
            '{1'b1, 8'h16, 1'b1, 5'd1, 8'h31},
            '{1'b1, 8'h5A, 1'b1, 5'd1, 8'h0D},
            '{1'b1, 8'h29, 1'b0, 5'd2, 8'h0D},
            '{1'b1, 8'h66, 1'b1, 5'd0, 8'h00},
            '{1'b1, 8'h45, 1'b0, 5'd1, 8'h30},
            '{1'b1, 8'h66, 1'b1, 5'd0, 8'h00}
        };

        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_count", 8'(count), 8'h00);
        chk("rst_empty", 8'(empty), 8'h01);
        chk("rst_full", 8'(full), 8'h00);
        chk("rst_ovf", 8'(overflow), 8'h00);
        chk("rst_dout", dout, 8'h00);

        foreach (vt[i]) begin
            step(1'b0, vt[i].kc, vt[i].k, vt[i].rd);
            chk($sformatf("vec%0d_count", i), 8'(count), 8'(vt[i].e_cnt));
            chk($sformatf("vec%0d_empty", i), 8'(empty), 8'(vt[i].e_cnt == 0));
            if (vt[i].e_cnt != 0) chk($sformatf("vec%0d_dout", i), dout, vt[i].e_dout);
            chk_model();
        end

        // full buffer: simultaneous push and pop keeps it full without overflow
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, LET[i], 1'b0);
        chk("fill_full", 8'(full), 8'h01);
        step(1'b0, 1'b1, 8'h45, 1'b1);
        chk("fullpp_count", 8'(count), 8'(DEPTH));
        chk("fullpp_ovf", 8'(overflow), 8'h00);
        chk("fullpp_dout", dout, 8'h42);
        chk_model();

        // overflow: ninth push dropped, first eight drain in order
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            step(1'b0, 1'b1, DIG[i], 1'b0);
            if (i == DEPTH) chk("ovf_full8", 8'(full), 8'h01);
        end
        chk("ovf_set", 8'(overflow), 8'h01);
        chk("ovf_count", 8'(count), 8'(DEPTH));
        for (int i = 1; i <= DEPTH; i++) begin
            chk($sformatf("ovf_pop%0d", i), dout, 8'(8'h30 + i));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("ovf_drained", 8'(empty), 8'h01);
        chk("ovf_sticky", 8'(overflow), 8'h01);
        chk_model();

        // reset wins over a simultaneous push and discards contents
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, LET[i], 1'b0);
        step(1'b1, 1'b1, 8'h45, 1'b0);
        chk("rstkc_count", 8'(count), 8'h00);
        chk("rstkc_empty", 8'(empty), 8'h01);
        chk("rstkc_ovf", 8'(overflow), 8'h00);
        step(1'b0, 1'b1, 8'h45, 1'b0);
        chk("rstkc_dout", dout, 8'h30);
        chk_model();

        for (int c = 0; c < 3000; c++) begin
            int         r;
            int         idx;
            logic [7:0] k;
            r = $urandom_range(0, 9);
            idx = $urandom_range(0, 37);
            k = idx < 10 ? DIG[idx] : idx < 36 ? LET[idx - 10] : idx == 36 ? 8'h29 : 8'h5A;
            if (r >= 5) k = r < 7 ? 8'h66 : 8'($urandom);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, k,
                 ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            chk_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_buffer.md
KEY_BUFFER -- requirements
Module: key_buffer

Interface
REQ-001 Parameter: DEPTH, 8, number of FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  system clock; all state updates on rising edge; one clock domain.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 key  input  8  PS/2 scan code of the most recently released key, valid when keyChange=1.
REQ-005 keyChange  input  1  single-cycle pulse, in the clk domain, marking a new key release.
REQ-006 rd_en  input  1  pop request for the head entry.
REQ-007 dout  output  8  ASCII code of the head entry, first-word-fall-through.
REQ-008 empty  output  1  high when count=0.
REQ-009 full  output  1  high when count=DEPTH.
REQ-010 count  output  5  number of stored entries, 0..DEPTH.
REQ-011 overflow  output  1  sticky flag, set when a push is dropped.

Function
REQ-012 Decode is combinational from key: digits 45,16,1E,26,25,2E,36,3D,3E,46 -> ASCII '0'..'9' (30h..39h).
REQ-013 Letters decode to uppercase ASCII: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
REQ-014 Other decodes: 29h -> 20h (space); 5Ah -> 0Dh (enter).
REQ-015 Scan code 66h (backspace) is a delete command and is never stored.
REQ-016 Any other scan code, including F0h and E0h, is ignored with no state change.
REQ-017 Push: keyChange=1 with a printable code (REQ-012..014) and not full -> write at tail, tail+1 mod DEPTH, count+1, all at the same edge.
REQ-018 Push latency: dout, empty and count reflect the push in the cycle after the keyChange edge.
REQ-019 Pop: rd_en=1 and not empty -> head+1 mod DEPTH, count-1; dout then shows the next entry.
REQ-020 rd_en while empty is ignored.
REQ-021 Delete: keyChange=1 with key=66h and not empty -> tail-1 mod DEPTH, count-1 (newest entry removed).
REQ-022 Delete while empty is ignored.
REQ-023 Push and pop in the same cycle, count in 1..DEPTH-1: both occur; count unchanged.
REQ-024 Push and pop in the same cycle when empty: only the push occurs; count becomes 1.
REQ-025 Push and pop in the same cycle when full: both occur; count stays DEPTH; no overflow.
REQ-026 Push when full without pop: data dropped, pointers unchanged, overflow set to 1.
REQ-027 Delete and pop in the same cycle, count=1: the single entry is removed once; count becomes 0.
REQ-028 Delete and pop in the same cycle, count>=2: head+1 and tail-1; count decreases by 2.
REQ-029 dout is don't-care while empty; the bench shall not check it.
REQ-030 Flags: full=(count==DEPTH), empty=(count==0), both derived from registered count; pointers wrap modulo DEPTH.

Reset
REQ-031 On reset=1 at a rising edge: head=0, tail=0, count=0, empty=1, full=0, overflow=0, dout=00h.
REQ-032 Reset overrides keyChange and rd_en in the same cycle.
REQ-033 Reset mid-operation discards all stored entries.
REQ-034 overflow clears only on reset.

Verification
REQ-035 Reset, then key=16h pulse -> next cycle empty=0, count=1, dout=31h; then rd_en pulse -> empty=1, count=0.
REQ-036 Keys 1Ch,32h,21h pushed, then key=66h -> count=2; pops return 41h then 42h; 43h is never output.
REQ-037 Push 9 codes with DEPTH=8 -> full=1 after the 8th; 9th is dropped; overflow=1; 8 pops return the first 8 in order; overflow stays 1 until reset.
REQ-038 key=F0h, 76h and E0h pulses -> count remains 0 and empty=1; key=66h while empty -> no change.
REQ-039 With count=1, keyChange(5Ah) and rd_en in the same cycle -> count=1, dout=0Dh; with count=8, push+pop -> count=8, overflow=0.
REQ-040 Fill with 4 entries, assert reset together with keyChange(45h) -> next cycle count=0, empty=1, overflow=0; a subsequent push of 45h yields dout=30h.
